// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory fetch controller.
//   imem_state_e     : controller state (boot load / processor running)
//   IMEM_NOP         : instruction returned for out-of-range fetches
//   IMEM_ADDR_W_DEF  : default word-address width of the instruction memory
//   IMEM_DATA_W_DEF  : default instruction width
package imem_pkg;

  typedef enum logic {
    IMEM_LOAD = 1'b0,
    IMEM_RUN  = 1'b1
  } imem_state_e;

  localparam logic [31:0] IMEM_NOP        = 32'h0000_0000;
  localparam int unsigned IMEM_ADDR_W_DEF = 16;
  localparam int unsigned IMEM_DATA_W_DEF = 32;

endpackage

// File: rtl/imem_starve_ctr.sv
// Saturating starvation counter for the loader port.
//   clk, rst : clock, asynchronous active-low reset
//   inc      : loader was denied this cycle
//   clr      : loader was served or withdrew its request
//   forced   : count has reached STARVE_MAX; this cycle belongs to the loader
// The count clears on the cycle it reports forced, so a continuously denied
// loader is served once every STARVE_MAX+1 cycles.
module imem_starve_ctr #(
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic forced
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign forced = (cnt_q == CNT_W'(STARVE_MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (clr || forced) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Single-port instruction-memory controller. Shares the memory port between
// the processor fetch path and a program-loader write stream.
//
// Optional feature macro: IMEM_LOADER_EN
//   defined   : boot load in LOAD state, then RUN with fetch priority and a
//               starvation-bounded loader (patch writes).
//   undefined : loader removed, ld_ready = 0, mem_we = 0; the controller
//               enters RUN on the first clock after reset and the memory is
//               expected to be preloaded.
//
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   ld_valid/ld_ready     loader handshake; ld_addr/ld_data/ld_last payload
//   f_req/f_addr/f_gnt    fetch request, word address (PC), grant
//   f_valid/f_instr       fetch result, two cycles after the grant
//   cpu_run               processor release
//   fault                 sticky out-of-range fetch flag
//   mem_*                 memory port; mem_rdata valid the cycle after a read
module imem_fetch_ctrl
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W     = IMEM_ADDR_W_DEF,
  parameter int unsigned DATA_W     = IMEM_DATA_W_DEF,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  input  logic              f_req,
  input  logic [31:0]       f_addr,
  output logic              f_gnt,
  output logic              f_valid,
  output logic [DATA_W-1:0] f_instr,
  output logic              cpu_run,
  output logic              fault,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  imem_state_e state_q, state_d;

  logic              ld_acc;
  logic              f_oor;
  logic              s1_vld_q, s1_vld_d;
  logic              s1_oor_q, s1_oor_d;
  logic              f_valid_q, f_valid_d;
  logic [DATA_W-1:0] f_instr_q, f_instr_d;
  logic              fault_q, fault_d;

  assign f_oor = |f_addr[31:ADDR_W];

`ifdef IMEM_LOADER_EN
  logic starve_forced;
  logic ld_forced;
  logic starve_inc;
  logic starve_clr;

  // A forced slot only matters while the loader is still asking.
  assign ld_forced  = starve_forced & ld_valid;
  assign starve_inc = (state_q == IMEM_RUN) & ld_valid & ~ld_ready;
  assign starve_clr = ld_acc | ~ld_valid;

  imem_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk    (clk),
    .rst    (rst),
    .inc    (starve_inc),
    .clr    (starve_clr),
    .forced (starve_forced)
  );
`else
  logic unused_ld;
  assign unused_ld = ^{ld_valid, ld_addr, ld_data, ld_last};
`endif

  // Arbitration and state transitions.
  always_comb begin
    state_d  = state_q;
    f_gnt    = 1'b0;
    ld_ready = 1'b0;
    ld_acc   = 1'b0;
`ifdef IMEM_LOADER_EN
    case (state_q)
      IMEM_LOAD: begin
        // Gated by rst so the port reads as not-ready while in reset.
        ld_ready = rst;
        if (ld_valid && ld_last) begin
          state_d = IMEM_RUN;
        end
      end
      IMEM_RUN: begin
        f_gnt    = f_req & ~ld_forced;
        ld_ready = ld_valid & (~f_req | ld_forced);
      end
      default: state_d = IMEM_LOAD;
    endcase
    ld_acc = ld_valid & ld_ready;
`else
    state_d = IMEM_RUN;
    f_gnt   = f_req & (state_q == IMEM_RUN);
`endif
  end

  // Memory port mux. An out-of-range fetch is granted but leaves the port idle.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = f_addr[ADDR_W-1:0];
    mem_wdata = '0;
`ifdef IMEM_LOADER_EN
    if (ld_acc) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = ld_addr;
      mem_wdata = ld_data;
    end else
`endif
    if (f_gnt && !f_oor) begin
      mem_en = 1'b1;
    end
  end

  // Two-stage return pipeline: stage 1 tracks the outstanding read while the
  // memory produces data, stage 2 registers the instruction.
  always_comb begin
    s1_vld_d  = f_gnt;
    s1_oor_d  = f_gnt & f_oor;
    f_valid_d = s1_vld_q;
    f_instr_d = f_instr_q;
    if (s1_vld_q) begin
      f_instr_d = s1_oor_q ? DATA_W'(IMEM_NOP) : mem_rdata;
    end
    fault_d = fault_q | (f_gnt & f_oor);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IMEM_LOAD;
      s1_vld_q  <= 1'b0;
      s1_oor_q  <= 1'b0;
      f_valid_q <= 1'b0;
      f_instr_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      s1_vld_q  <= s1_vld_d;
      s1_oor_q  <= s1_oor_d;
      f_valid_q <= f_valid_d;
      f_instr_q <= f_instr_d;
      fault_q   <= fault_d;
    end
  end

  assign f_valid = f_valid_q;
  assign f_instr = f_instr_q;
  assign fault   = fault_q;
  assign cpu_run = (state_q == IMEM_RUN);

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Controller for the single-port instruction memory. It owns the memory's only port and shares it between the processor fetch path and a program-loader stream. The loader writes a program image after reset; the processor is then released and fetches instructions with a fixed two-cycle latency. Later loader writes (patching) are arbitrated against fetches under a starvation bound.

## Interface
Parameters:
- ADDR_W, 16, word-address width of the instruction memory (depth 2**ADDR_W)
- DATA_W, 32, instruction width
- STARVE_MAX, 8, consecutive denied loader cycles before the loader is forced a grant (≥1)

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- ld_valid  in  1  loader has a write pending
- ld_ready  out  1  loader write accepted this cycle
- ld_addr  in  ADDR_W  loader word address
- ld_data  in  DATA_W  loader write data
- ld_last  in  1  qualifies the final word of the boot image
- f_req  in  1  fetch request
- f_addr  in  32  fetch word address (PC)
- f_gnt  out  1  fetch accepted this cycle
- f_valid  out  1  f_instr carries a fetch result
- f_instr  out  DATA_W  fetched instruction
- cpu_run  out  1  processor release; low during boot load
- fault  out  1  sticky: an out-of-range fetch occurred
- mem_en, mem_we  out  1  memory port enable / write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  synchronous read data, valid in the cycle after mem_en & !mem_we

## Operation
- States: LOAD (reset state) and RUN.
- LOAD behaviour:
  - ld_ready = 1 and f_gnt = 0.
  - Each accepted ld_valid drives mem_en = mem_we = 1 with ld_addr / ld_data in the same cycle.
  - An accepted write with ld_last = 1 moves the FSM to RUN on that edge.
- RUN behaviour:
  - cpu_run = 1.
  - Fetch has priority: f_gnt = f_req, unless the loader is forced.
  - ld_ready = ld_valid & (!f_req | forced).
- Starvation counter:
  - Increments on each RUN cycle with ld_valid & !ld_ready.
  - Clears when a loader write is accepted or ld_valid drops.
  - When the count equals STARVE_MAX, that cycle is forced: the loader wins, f_gnt = 0, and the counter clears.
- Granted fetch:
  - mem_en = 1, mem_we = 0, mem_addr = f_addr[ADDR_W-1:0].
  - If f_addr[31:ADDR_W] ≠ 0, no memory access is made. The result is returned as NOP 32'h00000000 and fault is set until reset.
- Both ports idle: mem_en = 0.
- Fetch results are returned in order, and there is no cancel mechanism.

## Timing
- Reset values: state LOAD, f_valid 0, f_instr 32'h00000000, cpu_run 0, fault 0, starvation count 0. mem_en, mem_we and ld_ready are 0 while rst = 0.
- Fetch latency:
  - A fetch granted in cycle N produces f_valid = 1 with registered f_instr in cycle N+2.
  - f_instr holds its last value when f_valid = 0.
- Throughput is one fetch per cycle, fully pipelined.
- A loader write in cycle N is visible to a fetch granted in cycle N+1 or later.
- Simultaneous ld_valid and f_req in RUN: the fetch wins, except on a forced cycle.
- ld_last accepted in cycle N: cpu_run rises in cycle N+1, and f_req is honoured from N+1.
- ld_last in RUN has no effect.
- Reset asserted mid-operation: all in-flight reads are discarded. f_valid is not asserted for them after release, and the FSM returns to LOAD.

## Configuration
- IMEM_LOADER_EN defined:
  - Full behaviour as described above.
- IMEM_LOADER_EN undefined:
  - The loader path and starvation counter are removed.
  - ld_ready is tied to 0 and mem_we to 0.
  - The FSM leaves reset directly in RUN, and cpu_run is 1 from the first cycle after rst deasserts. The memory is preloaded externally.

## Structure
- Package imem_pkg holds:
  - the state enum (IMEM_LOAD, IMEM_RUN);
  - the NOP constant 32'h00000000;
  - default ADDR_W / DATA_W values.
- One sub-module, imem_starve_ctr, holds the saturating starvation counter. It has inputs inc, clr and output forced, and is instantiated only under IMEM_LOADER_EN.

## Test plan
- Boot load: after reset, write addresses 0..3 (with ld_last on address 3), then fetch addresses 0..3 back-to-back. Required: cpu_run rises the cycle after the last write, and four consecutive f_valid return the written data with 2-cycle latency.
- Fetch during LOAD: drive f_req = 1 with no load completed. Required: f_gnt = 0, f_valid = 0, and mem_we accesses only.
- Starvation: in RUN with STARVE_MAX = 8, hold f_req = 1 every cycle and ld_valid = 1. Required: ld_ready pulses exactly once every 9 cycles, with f_gnt = 0 in those cycles.
- Out of range: fetch f_addr = 32'h0001_0000 with ADDR_W = 16. Required: f_instr = 0 with f_valid 2 cycles later, fault = 1 and stays 1, and mem_en = 0 in the grant cycle.
- Write-then-read: in RUN, patch address 5 with 32'hDEADBEEF, then fetch address 5 the next cycle. Required: f_instr = 32'hDEADBEEF.
- Reset mid-fetch: assert rst low one cycle after a fetch grant. Required: f_valid never asserts for that fetch, and the state returns to LOAD with cpu_run = 0.
